// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
//   Shared sizing and helpers for the register scoreboard. The ID/EX and
//   EX/MEM pipeline registers import the same widths so that register
//   indices and pending counters agree across the pipeline.
//   Contents: register count/index width, pending counter width, total
//   width, the saturation value and the source "modified" query function.
package reg_scoreboard_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 2;
    localparam int TOTAL_W    = CNT_W + REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0]      cnt_t;
    typedef logic [TOTAL_W-1:0]    total_t;

    localparam cnt_t CNT_MAX = '1;

    // A source is "modified" while it has a pending write, except when the
    // only remaining write is retiring right now (writeback bypass).
    function automatic logic src_modified(input reg_idx_t rd,
                                          input cnt_t     rd_cnt,
                                          input logic     wb_valid,
                                          input reg_idx_t wb_reg);
        return (rd != '0) && (rd_cnt != '0) &&
               !(wb_valid && (wb_reg == rd) && (rd_cnt == cnt_t'(1)));
    endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if
//   Bundles the ID-side issue/query signals and the WB-side retire signals
//   of the register scoreboard.
//   master : pipeline side (drives issue, writeback, flush and queries)
//   slave  : scoreboard side (answers modi1/modi2, issue_full, totals, errors)
//
// Handshake: there is no ready signal. issue_valid/wb_valid are single-cycle
// qualifiers sampled at the rising clock edge. issue_full is the only
// back-pressure: the ID stage must not raise issue_valid for a register while
// issue_full is high for it; an issue that ignores this is dropped and flagged
// in err_overflow.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    logic     issue_valid;
    reg_idx_t issue_reg;
    logic     wb_valid;
    reg_idx_t wb_reg;
    logic     flush;
    reg_idx_t rd1_reg;
    reg_idx_t rd2_reg;
    logic     modi1;
    logic     modi2;
    logic     issue_full;
    total_t   pending_total;
    logic     err_overflow;
    logic     err_underflow;

    modport master (
        output issue_valid, issue_reg, wb_valid, wb_reg, flush, rd1_reg, rd2_reg,
        input  modi1, modi2, issue_full, pending_total, err_overflow, err_underflow
    );

    modport slave (
        input  issue_valid, issue_reg, wb_valid, wb_reg, flush, rd1_reg, rd2_reg,
        output modi1, modi2, issue_full, pending_total, err_overflow, err_underflow
    );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter
//   One saturating up/down pending-write counter.
//   clk      rising-edge clock
//   rst      asynchronous reset, active-low
//   clr_i    synchronous clear, overrides inc/dec
//   inc_i    request +1 (ignored at saturation, reported on ovf_o)
//   dec_i    request -1 (ignored at zero, reported on unf_o)
//   cnt_o    current count
//   ovf_o    combinational pulse: inc_i on a saturated counter
//   unf_o    combinational pulse: dec_i on a zero counter
module sb_counter
    import reg_scoreboard_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    input  logic dec_i,
    output cnt_t cnt_o,
    output logic ovf_o,
    output logic unf_o
);

    cnt_t cnt_q;
    cnt_t cnt_d;
    logic inc_ok;
    logic dec_ok;

    assign inc_ok = inc_i && (cnt_q != CNT_MAX);
    assign dec_ok = dec_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_ok && !dec_ok) begin
            cnt_d = cnt_q + cnt_t'(1);
        end else if (dec_ok && !inc_ok) begin
            cnt_d = cnt_q - cnt_t'(1);
        end
        // inc_ok && dec_ok: one write enters, one leaves, count unchanged.
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flush discards concurrent requests, so they cannot raise errors.
    assign ovf_o = !clr_i && inc_i && (cnt_q == CNT_MAX);
    assign unf_o = !clr_i && dec_i && (cnt_q == '0);
    assign cnt_o = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Tracks architectural registers with writes in flight between ID/EX issue
//   and MEM/WB writeback, and answers the two source-operand "modified"
//   queries used by ID/EX to raise its block condition. Register 0 is
//   hard-wired and has no counter.
//   clk    rising-edge clock
//   rst    asynchronous reset, active-low
//   sb     scoreboard interface (slave side): issue/wb/flush/rd1/rd2 in,
//          modi1/modi2/issue_full/pending_total/err_overflow/err_underflow out
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input logic             clk,
    input logic             rst,
    reg_scoreboard_if.slave sb
);

    cnt_t                 cnt_all [REG_COUNT];
    logic [REG_COUNT-1:1] inc_vec;
    logic [REG_COUNT-1:1] dec_vec;
    logic [REG_COUNT-1:1] ovf_vec;
    logic [REG_COUNT-1:1] unf_vec;

    // Register 0 reads as permanently idle.
    assign cnt_all[0] = '0;

    for (genvar i = 1; i < REG_COUNT; i++) begin : g_cnt
        assign inc_vec[i] = sb.issue_valid && (sb.issue_reg == REG_ADDR_W'(i));
        assign dec_vec[i] = sb.wb_valid    && (sb.wb_reg    == REG_ADDR_W'(i));

        sb_counter u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr_i (sb.flush),
            .inc_i (inc_vec[i]),
            .dec_i (dec_vec[i]),
            .cnt_o (cnt_all[i]),
            .ovf_o (ovf_vec[i]),
            .unf_o (unf_vec[i])
        );
    end

    cnt_t issue_cnt;
    cnt_t wb_cnt;
    cnt_t rd1_cnt;
    cnt_t rd2_cnt;

    assign issue_cnt = cnt_all[sb.issue_reg];
    assign wb_cnt    = cnt_all[sb.wb_reg];
    assign rd1_cnt   = cnt_all[sb.rd1_reg];
    assign rd2_cnt   = cnt_all[sb.rd2_reg];

    // Mirrors the counters' acceptance rules so the running total moves by
    // exactly the updates that were applied.
    logic issue_ok;
    logic retire_ok;

    assign issue_ok  = sb.issue_valid && (sb.issue_reg != '0) && (issue_cnt != CNT_MAX);
    assign retire_ok = sb.wb_valid    && (sb.wb_reg    != '0) && (wb_cnt    != '0);

    total_t total_q;
    total_t total_d;
    logic   ovf_q;
    logic   ovf_d;
    logic   unf_q;
    logic   unf_d;

    always_comb begin
        total_d = total_q;
        if (sb.flush) begin
            total_d = '0;
        end else if (issue_ok && !retire_ok) begin
            total_d = total_q + total_t'(1);
        end else if (retire_ok && !issue_ok) begin
            total_d = total_q - total_t'(1);
        end
    end

    // Error flags are sticky; only reset clears them (flush does not).
    assign ovf_d = ovf_q | (|ovf_vec);
    assign unf_d = unf_q | (|unf_vec);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            total_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            total_q <= total_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Queries see registered state only; an issue this cycle shows up next
    // cycle. The writeback in flight is bypassed inside src_modified.
    assign sb.modi1 = src_modified(sb.rd1_reg, rd1_cnt, sb.wb_valid, sb.wb_reg);
    assign sb.modi2 = src_modified(sb.rd2_reg, rd2_cnt, sb.wb_valid, sb.wb_reg);

    assign sb.issue_full    = (sb.issue_reg != '0) && (issue_cnt == CNT_MAX);
    assign sb.pending_total = total_q;
    assign sb.err_overflow  = ovf_q;
    assign sb.err_underflow = unf_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
//   Directed bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_scoreboard_if sb_if ();

    reg_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, away from the edge itself.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sb_if.issue_valid = 1'b0;
        sb_if.issue_reg   = '0;
        sb_if.wb_valid    = 1'b0;
        sb_if.wb_reg      = '0;
        sb_if.flush       = 1'b0;
    endtask

    task automatic issue(input logic [4:0] r);
        sb_if.issue_valid = 1'b1;
        sb_if.issue_reg   = r;
    endtask

    task automatic wb(input logic [4:0] r);
        sb_if.wb_valid = 1'b1;
        sb_if.wb_reg   = r;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        idle_inputs();
        sb_if.rd1_reg = '0;
        sb_if.rd2_reg = '0;

        // ---- Reset held with an issue request present ----
        issue(5'd3);
        sb_if.rd1_reg = 5'd3;
        repeat (2) next_cycle();
        chk("rst_modi1",  32'(sb_if.modi1), 32'd0);
        chk("rst_total",  32'(sb_if.pending_total), 32'd0);
        chk("rst_ovf",    32'(sb_if.err_overflow), 32'd0);
        chk("rst_unf",    32'(sb_if.err_underflow), 32'd0);
        chk("rst_full",   32'(sb_if.issue_full), 32'd0);
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        chk("rel_modi1", 32'(sb_if.modi1), 32'd0);
        issue(5'd3);
        #1;
        chk("rel_issue_same_cycle_modi1", 32'(sb_if.modi1), 32'd0);
        next_cycle();
        idle_inputs();
        #1;
        chk("rel_issue_seen_modi1", 32'(sb_if.modi1), 32'd1);
        chk("rel_issue_total", 32'(sb_if.pending_total), 32'd1);
        wb(5'd3);
        #1;
        chk("rel_wb_bypass_modi1", 32'(sb_if.modi1), 32'd0);
        next_cycle();
        idle_inputs();
        #1;
        chk("rel_wb_total", 32'(sb_if.pending_total), 32'd0);

        // ---- Issue r5, retire r5 three cycles later ----
        sb_if.rd1_reg = 5'd5;
        issue(5'd5);                      // cycle 1
        next_cycle();
        idle_inputs();
        #1;
        chk("ir_c2_modi1", 32'(sb_if.modi1), 32'd1);
        next_cycle();
        #1;
        chk("ir_c3_modi1", 32'(sb_if.modi1), 32'd1);
        next_cycle();
        wb(5'd5);                         // cycle 4
        #1;
        chk("ir_c4_bypass_modi1", 32'(sb_if.modi1), 32'd0);
        chk("ir_c4_total", 32'(sb_if.pending_total), 32'd1);
        next_cycle();
        idle_inputs();
        #1;
        chk("ir_c5_modi1", 32'(sb_if.modi1), 32'd0);
        chk("ir_c5_total", 32'(sb_if.pending_total), 32'd0);

        // ---- Saturation on r7 ----
        issue(5'd7);
        next_cycle();
        next_cycle();
        #1;
        chk("sat_2_full", 32'(sb_if.issue_full), 32'd0);
        chk("sat_2_total", 32'(sb_if.pending_total), 32'd2);
        next_cycle();
        #1;
        chk("sat_3_full", 32'(sb_if.issue_full), 32'd1);
        chk("sat_3_total", 32'(sb_if.pending_total), 32'd3);
        chk("sat_3_ovf", 32'(sb_if.err_overflow), 32'd0);
        next_cycle();                     // fourth issue edge
        idle_inputs();
        sb_if.issue_reg = 5'd7;           // full ignores issue_valid
        #1;
        chk("sat_4_ovf", 32'(sb_if.err_overflow), 32'd1);
        chk("sat_4_total", 32'(sb_if.pending_total), 32'd3);
        chk("sat_4_full_no_valid", 32'(sb_if.issue_full), 32'd1);
        wb(5'd7);
        repeat (3) next_cycle();
        idle_inputs();
        sb_if.issue_reg = 5'd7;
        #1;
        chk("sat_drain_total", 32'(sb_if.pending_total), 32'd0);
        chk("sat_drain_full", 32'(sb_if.issue_full), 32'd0);
        chk("sat_drain_ovf_sticky", 32'(sb_if.err_overflow), 32'd1);
        sb_if.issue_reg = '0;

        // ---- Simultaneous events on r9 ----
        sb_if.rd2_reg = 5'd9;
        issue(5'd9);
        next_cycle();
        idle_inputs();
        #1;
        chk("sim_r9_total", 32'(sb_if.pending_total), 32'd1);
        issue(5'd9);
        wb(5'd9);
        next_cycle();
        idle_inputs();
        #1;
        chk("sim_same_modi2", 32'(sb_if.modi2), 32'd1);
        chk("sim_same_total", 32'(sb_if.pending_total), 32'd1);
        issue(5'd2);
        wb(5'd9);
        #1;
        chk("sim_diff_bypass_modi2", 32'(sb_if.modi2), 32'd0);
        next_cycle();
        idle_inputs();
        sb_if.rd1_reg = 5'd2;
        #1;
        chk("sim_diff_total", 32'(sb_if.pending_total), 32'd1);
        chk("sim_diff_r9_modi2", 32'(sb_if.modi2), 32'd0);
        chk("sim_diff_r2_modi1", 32'(sb_if.modi1), 32'd1);
        wb(5'd2);
        next_cycle();
        idle_inputs();
        #1;
        chk("sim_clean_total", 32'(sb_if.pending_total), 32'd0);

        // ---- Register 0 and underflow ----
        sb_if.rd1_reg = '0;
        issue(5'd0);
        #1;
        chk("zero_full", 32'(sb_if.issue_full), 32'd0);
        next_cycle();
        idle_inputs();
        wb(5'd0);
        next_cycle();
        idle_inputs();
        #1;
        chk("zero_total", 32'(sb_if.pending_total), 32'd0);
        chk("zero_modi1", 32'(sb_if.modi1), 32'd0);
        chk("zero_no_unf", 32'(sb_if.err_underflow), 32'd0);
        wb(5'd4);
        next_cycle();
        idle_inputs();
        #1;
        chk("unf_set", 32'(sb_if.err_underflow), 32'd1);
        chk("unf_total", 32'(sb_if.pending_total), 32'd0);
        repeat (3) next_cycle();
        chk("unf_sticky", 32'(sb_if.err_underflow), 32'd1);

        // ---- Flush with r1=2, r6=1 pending and a concurrent issue of r8 ----
        issue(5'd1);
        next_cycle();
        next_cycle();
        issue(5'd6);
        next_cycle();
        idle_inputs();
        #1;
        chk("fl_pre_total", 32'(sb_if.pending_total), 32'd3);
        sb_if.flush = 1'b1;
        issue(5'd8);
        next_cycle();
        idle_inputs();
        sb_if.rd1_reg = 5'd1;
        sb_if.rd2_reg = 5'd6;
        #1;
        chk("fl_total", 32'(sb_if.pending_total), 32'd0);
        chk("fl_modi1_r1", 32'(sb_if.modi1), 32'd0);
        chk("fl_modi2_r6", 32'(sb_if.modi2), 32'd0);
        sb_if.rd1_reg = 5'd8;
        #1;
        chk("fl_r8_untracked", 32'(sb_if.modi1), 32'd0);
        chk("fl_keeps_ovf", 32'(sb_if.err_overflow), 32'd1);
        chk("fl_keeps_unf", 32'(sb_if.err_underflow), 32'd1);

        // ---- Asynchronous reset mid-cycle ----
        sb_if.rd1_reg = 5'd10;
        issue(5'd10);
        next_cycle();
        idle_inputs();
        #1;
        chk("ar_pre_modi1", 32'(sb_if.modi1), 32'd1);
        rst = 1'b0;                       // between clock edges
        #1;
        chk("ar_total", 32'(sb_if.pending_total), 32'd0);
        chk("ar_modi1", 32'(sb_if.modi1), 32'd0);
        chk("ar_ovf", 32'(sb_if.err_overflow), 32'd0);
        chk("ar_unf", 32'(sb_if.err_underflow), 32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
